// File: rtl/pcw_loader_pkg.sv
// Shared types for the boot-loader download sink: loader FSM states, the
// buffered {address, byte} entry and default sizing.
package pcw_loader_pkg;

    localparam int LOADER_FIFO_DEPTH = 4;
    localparam int LOADER_ADDR_W     = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2,
        EXEC  = 2'd3
    } loader_state_t;

    typedef struct packed {
        logic [LOADER_ADDR_W-1:0] addr;
        logic [7:0]               data;
    } loader_entry_t;

endpackage

// File: rtl/boot_download_sink_if.sv
// Download stream and RAM write port of the boot-loader sink. The environment
// (byte source + RAM arbiter) uses the master modport, the sink uses slave.
interface boot_download_sink_if #(
    parameter int ADDR_W = 16
);
    // Handshakes: dn_wr is a one-cycle valid with no ready; dn_wait is a
    // registered stop hint that leaves one cycle of slack. On the RAM side
    // mem_req is valid and mem_ack is ready: a write transfers in any cycle
    // where both are high, and mem_addr/mem_wdata hold while mem_req waits.
    logic              dn_go;
    logic              dn_wr;
    logic [ADDR_W-1:0] dn_addr;
    logic [7:0]        dn_data;
    logic              dn_wait;
    logic [ADDR_W-1:0] execute_addr;
    logic              execute_enable;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              mem_ack;

    modport master (
        output dn_go, dn_wr, dn_addr, dn_data, execute_addr, execute_enable, mem_ack,
        input  dn_wait, mem_req, mem_addr, mem_wdata
    );

    modport slave (
        input  dn_go, dn_wr, dn_addr, dn_data, execute_addr, execute_enable, mem_ack,
        output dn_wait, mem_req, mem_addr, mem_wdata
    );

endinterface

// File: rtl/loader_fifo.sv
// Synchronous FIFO for download entries. almost_full_o looks ahead: it reflects
// the occupancy after this cycle's push/pop so the owner can register it.
module loader_fifo
    import pcw_loader_pkg::*;
#(
    parameter int  DEPTH   = LOADER_FIFO_DEPTH,
    parameter type entry_t = loader_entry_t,
    localparam int PTR_W   = $clog2(DEPTH),
    localparam int CNT_W   = PTR_W + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  entry_t           wdata_i,
    input  logic             pop_i,
    output entry_t           rdata_o,
    output logic             full_o,
    output logic             almost_full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    entry_t           mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    assign almost_full_o = (count_d >= CNT_W'(DEPTH - 1));
    assign count_o       = count_q;
    assign rdata_o       = mem_q[rd_ptr_q];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
        end
    end

    // Storage needs no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/boot_download_sink.sv
// Boot-loader download sink: buffers {addr, byte} pairs, writes them to RAM,
// holds the CPU during the load and optionally jump-starts it afterwards.
module boot_download_sink
    import pcw_loader_pkg::*;
#(
    parameter int FIFO_DEPTH = LOADER_FIFO_DEPTH,
    parameter int ADDR_W     = LOADER_ADDR_W
) (
    input  logic                 clk_sys,
    input  logic                 reset,
    boot_download_sink_if.slave  bus,
    output logic                 cpu_hold,
    output logic                 exec_start,
    output logic [ADDR_W-1:0]    exec_pc,
    output logic                 busy,
    output logic                 overflow_err,
    output logic [ADDR_W:0]      byte_count
);

    localparam int BCNT_W = ADDR_W + 1;
    localparam int FCNT_W = $clog2(FIFO_DEPTH) + 1;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [7:0]        data;
    } entry_t;

    loader_state_t     state_q, state_d;
    logic              dn_go_q, go_rise;
    logic              cpu_hold_q, cpu_hold_d;
    logic              exec_pending_q, exec_pending_d;
    logic [ADDR_W-1:0] exec_pc_q, exec_pc_d;
    logic              overflow_q, overflow_d;
    logic [BCNT_W-1:0] byte_count_q, byte_count_d;
    logic              dn_wait_q;

    logic              fifo_push, fifo_pop;
    logic              fifo_full, fifo_almost_full, fifo_empty;
    logic [FCNT_W-1:0] fifo_count;
    entry_t            fifo_wdata, fifo_head;

    assign go_rise         = bus.dn_go && !dn_go_q;
    assign fifo_push       = (state_q == LOAD) && bus.dn_wr;
    assign fifo_pop        = bus.mem_req && bus.mem_ack;
    assign fifo_wdata.addr = bus.dn_addr;
    assign fifo_wdata.data = bus.dn_data;

    loader_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk_i         (clk_sys),
        .rst_i         (reset),
        .push_i        (fifo_push),
        .wdata_i       (fifo_wdata),
        .pop_i         (fifo_pop),
        .rdata_o       (fifo_head),
        .full_o        (fifo_full),
        .almost_full_o (fifo_almost_full),
        .empty_o       (fifo_empty),
        .count_o       (fifo_count)
    );

    assign bus.mem_req   = !fifo_empty;
    assign bus.mem_addr  = fifo_head.addr;
    assign bus.mem_wdata = fifo_head.data;
    assign bus.dn_wait   = dn_wait_q;

    always_comb begin
        state_d        = state_q;
        cpu_hold_d     = cpu_hold_q;
        exec_pending_d = exec_pending_q;
        exec_pc_d      = exec_pc_q;
        overflow_d     = overflow_q;
        byte_count_d   = byte_count_q;
        exec_start     = 1'b0;

        if (fifo_pop && (byte_count_q != '1)) byte_count_d = byte_count_q + BCNT_W'(1);
        if (fifo_push && fifo_full) overflow_d = 1'b1;
        if (((state_q == LOAD) || (state_q == DRAIN)) && bus.execute_enable) begin
            exec_pending_d = 1'b1;
            exec_pc_d      = bus.execute_addr;
        end

        case (state_q)
            IDLE: begin
                if (go_rise) begin
                    state_d        = LOAD;
                    cpu_hold_d     = 1'b1;
                    byte_count_d   = '0;
                    overflow_d     = 1'b0;
                    exec_pending_d = 1'b0;
                end
            end
            LOAD: begin
                if (!bus.dn_go) state_d = DRAIN;
            end
            DRAIN: begin
                // A request arriving in the final drain cycle still counts.
                if (go_rise) begin
                    state_d        = LOAD;
                    exec_pending_d = 1'b0;
                end else if (fifo_count == '0) begin
                    state_d        = exec_pending_d ? EXEC : IDLE;
                    cpu_hold_d     = 1'b0;
                    exec_pending_d = 1'b0;
                end
            end
            EXEC: begin
                exec_start = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q        <= IDLE;
            dn_go_q        <= 1'b0;
            cpu_hold_q     <= 1'b0;
            exec_pending_q <= 1'b0;
            exec_pc_q      <= '0;
            overflow_q     <= 1'b0;
            byte_count_q   <= '0;
            dn_wait_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            dn_go_q        <= bus.dn_go;
            cpu_hold_q     <= cpu_hold_d;
            exec_pending_q <= exec_pending_d;
            exec_pc_q      <= exec_pc_d;
            overflow_q     <= overflow_d;
            byte_count_q   <= byte_count_d;
            dn_wait_q      <= fifo_almost_full;
        end
    end

    assign cpu_hold     = cpu_hold_q;
    assign busy         = (state_q != IDLE);
    assign overflow_err = overflow_q;
    assign byte_count   = byte_count_q;
    assign exec_pc      = (state_q == EXEC) ? exec_pc_q : '0;

endmodule

// File: tb/tb_boot_download_sink.sv
// Directed + randomized bench for boot_download_sink with a write scoreboard
// and a byte-image model of RAM.
module tb_boot_download_sink;

    localparam int ADDR_W = 16;
    localparam int LIMIT  = 5000;

    logic              clk_sys = 1'b0;
    logic              reset;
    logic              cpu_hold, exec_start, busy, overflow_err;
    logic [ADDR_W-1:0] exec_pc;
    logic [ADDR_W:0]   byte_count;

    int errors = 0;
    int checks = 0;

    boot_download_sink_if #(.ADDR_W(ADDR_W)) bus ();

    boot_download_sink #(.FIFO_DEPTH(4), .ADDR_W(ADDR_W)) dut (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .bus          (bus.slave),
        .cpu_hold     (cpu_hold),
        .exec_start   (exec_start),
        .exec_pc      (exec_pc),
        .busy         (busy),
        .overflow_err (overflow_err),
        .byte_count   (byte_count)
    );

    always #5 clk_sys = ~clk_sys;

    // Scoreboard and model state
    logic [23:0] exp_q[$];
    logic [7:0]  ram [int];
    logic [7:0]  img [int];
    int          wr_count = 0;
    int          exec_pulses = 0;
    int          exec_wr_count = 0;
    logic [15:0] exec_pc_seen = '0;
    int          ack_mode = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    // RAM side: ack policy applied just after each edge.
    always @(posedge clk_sys) begin
        #1;
        case (ack_mode)
            0:       bus.mem_ack = 1'b0;
            1:       bus.mem_ack = 1'b1;
            default: bus.mem_ack = ($urandom_range(0, 3) == 0);
        endcase
    end

    // Inputs settle 1 ns after the edge, so at negedge a req&ack pair will transfer.
    always @(negedge clk_sys) begin
        if (!reset && bus.mem_req && bus.mem_ack) begin
            if (exp_q.size() == 0) begin
                check("wr_unexpected", 32'd1, 32'd0);
            end else begin
                check("wr_order", {8'h0, bus.mem_addr, bus.mem_wdata}, {8'h0, exp_q.pop_front()});
            end
            ram[int'(bus.mem_addr)] = bus.mem_wdata;
            wr_count++;
        end
        if (!reset && exec_start) begin
            exec_pulses++;
            exec_pc_seen  = exec_pc;
            exec_wr_count = wr_count;
        end
    end

    task automatic send_byte(input logic [15:0] a, input logic [7:0] d);
        int n = 0;
        while (bus.dn_wait && n < LIMIT) begin
            tick();
            n++;
        end
        bus.dn_wr   = 1'b1;
        bus.dn_addr = a;
        bus.dn_data = d;
        exp_q.push_back({a, d});
        img[int'(a)] = d;
        tick();
        bus.dn_wr = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < LIMIT) begin
            tick();
            n++;
        end
        check(tag, 32'(n < LIMIT), 32'd1);
    endtask

    initial begin
        #800us;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses0, wr0, mism;
        logic [7:0] d;

        reset              = 1'b1;
        bus.dn_go          = 1'b0;
        bus.dn_wr          = 1'b0;
        bus.dn_addr        = '0;
        bus.dn_data        = '0;
        bus.execute_addr   = '0;
        bus.execute_enable = 1'b0;
        bus.mem_ack        = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // Reset state
        check("rst_cpu_hold", cpu_hold, 0);
        check("rst_busy", busy, 0);
        check("rst_mem_req", bus.mem_req, 0);
        check("rst_dn_wait", bus.dn_wait, 0);
        check("rst_overflow", overflow_err, 0);
        check("rst_byte_count", byte_count, 0);
        check("rst_exec_start", exec_start, 0);

        // Basic load with ack tied high
        ack_mode = 1;
        bus.dn_go = 1'b1;
        tick();
        check("basic_busy", busy, 1);
        check("basic_hold", cpu_hold, 1);
        send_byte(16'h0000, 8'hF3);
        check("basic_latency_req", bus.mem_req, 1);
        send_byte(16'h0001, 8'h31);
        send_byte(16'h0002, 8'h00);
        bus.dn_go = 1'b0;
        tick();
        wait_idle("basic_idle_timeout");
        check("basic_byte_count", byte_count, 3);
        check("basic_hold_release", cpu_hold, 0);
        check("basic_ram0", ram[0], 8'hF3);
        check("basic_ram1", ram[1], 8'h31);
        check("basic_ram2", ram[2], 8'h00);
        check("basic_no_exec", exec_pulses, 0);
        check("basic_q_empty", exp_q.size(), 0);

        // Execute after a 276-byte load, 1-in-4 ack, random source gaps
        ack_mode = 2;
        bus.dn_go = 1'b1;
        tick();
        for (int i = 0; i < 276; i++) begin
            d = 8'($urandom);
            send_byte(16'(i), d);
            repeat ($urandom_range(0, 1)) tick();
        end
        bus.dn_go          = 1'b0;
        bus.execute_enable = 1'b1;
        bus.execute_addr   = 16'h0000;
        tick();
        bus.execute_enable = 1'b0;
        wait_idle("exec_idle_timeout");
        tick();
        check("exec_pulses", exec_pulses, 1);
        check("exec_pc", exec_pc_seen, 16'h0000);
        check("exec_after_last_ack", exec_wr_count, 3 + 276);
        check("exec_byte_count", byte_count, 276);
        mism = 0;
        for (int i = 0; i < 276; i++) if (ram[i] !== img[i]) mism++;
        check("exec_ram_image", mism, 0);
        check("exec_hold_release", cpu_hold, 0);

        // Backpressure with ack held low
        ack_mode = 0;
        bus.dn_go = 1'b1;
        tick();
        send_byte(16'h0300, 8'hA0);
        send_byte(16'h0301, 8'hA1);
        check("bp_wait_at_2", bus.dn_wait, 0);
        send_byte(16'h0302, 8'hA2);
        check("bp_wait_at_3", bus.dn_wait, 1);
        tick();
        check("bp_head_stable", bus.mem_addr, 16'h0300);
        ack_mode = 1;
        send_byte(16'h0303, 8'hA3);
        send_byte(16'h0304, 8'hA4);
        bus.dn_go = 1'b0;
        tick();
        wait_idle("bp_idle_timeout");
        check("bp_no_overflow", overflow_err, 0);
        check("bp_byte_count", byte_count, 5);
        check("bp_q_empty", exp_q.size(), 0);

        // Overflow: 6 strobes ignoring dn_wait, first 4 kept
        ack_mode = 0;
        bus.dn_go = 1'b1;
        tick();
        for (int i = 0; i < 6; i++) begin
            bus.dn_wr   = 1'b1;
            bus.dn_addr = 16'(16'h0100 + i);
            bus.dn_data = 8'(8'h50 + i);
            if (i < 4) exp_q.push_back({16'(16'h0100 + i), 8'(8'h50 + i)});
            tick();
        end
        bus.dn_wr = 1'b0;
        check("ovf_flag", overflow_err, 1);
        check("ovf_wait", bus.dn_wait, 1);
        check("ovf_no_writes", byte_count, 0);
        ack_mode = 1;
        bus.dn_go = 1'b0;
        tick();
        wait_idle("ovf_idle_timeout");
        check("ovf_sticky", overflow_err, 1);
        check("ovf_byte_count", byte_count, 4);
        check("ovf_q_empty", exp_q.size(), 0);
        bus.dn_go = 1'b1;
        tick();
        check("ovf_clear_on_go", overflow_err, 0);
        check("ovf_count_clear", byte_count, 0);
        bus.dn_go = 1'b0;
        tick();
        wait_idle("ovf2_idle_timeout");

        // Reset in DRAIN with two entries pending
        ack_mode = 0;
        pulses0 = exec_pulses;
        bus.dn_go = 1'b1;
        tick();
        send_byte(16'h0200, 8'h11);
        send_byte(16'h0201, 8'h22);
        bus.execute_enable = 1'b1;
        bus.execute_addr   = 16'h4321;
        tick();
        bus.execute_enable = 1'b0;
        bus.dn_go = 1'b0;
        tick();
        tick();
        check("rd_in_drain", busy, 1);
        check("rd_req_pending", bus.mem_req, 1);
        reset = 1'b1;
        exp_q.delete();
        tick();
        reset = 1'b0;
        check("rd_mem_req", bus.mem_req, 0);
        check("rd_cpu_hold", cpu_hold, 0);
        check("rd_busy", busy, 0);
        check("rd_byte_count", byte_count, 0);
        wr0 = wr_count;
        ack_mode = 1;
        repeat (5) tick();
        check("rd_no_exec", exec_pulses, pulses0);
        check("rd_no_writes", wr_count, wr0);

        // Re-trigger during DRAIN clears the pending execute
        ack_mode = 0;
        bus.dn_go = 1'b1;
        tick();
        send_byte(16'h0400, 8'h01);
        bus.execute_enable = 1'b1;
        bus.execute_addr   = 16'h1234;
        send_byte(16'h0401, 8'h02);
        bus.execute_enable = 1'b0;
        bus.dn_go = 1'b0;
        repeat (3) tick();
        bus.dn_go = 1'b1;
        tick();
        check("rt_back_to_load", busy, 1);
        send_byte(16'h0402, 8'h03);
        bus.dn_go = 1'b0;
        tick();
        ack_mode = 1;
        wait_idle("rt_idle_timeout");
        tick();
        check("rt_no_exec", exec_pulses, pulses0);
        check("rt_byte_count", byte_count, 3);

        // Re-trigger followed by a fresh execute request
        ack_mode = 0;
        bus.dn_go = 1'b1;
        tick();
        bus.execute_enable = 1'b1;
        bus.execute_addr   = 16'h1234;
        send_byte(16'h0500, 8'hC1);
        bus.execute_enable = 1'b0;
        bus.dn_go = 1'b0;
        repeat (2) tick();
        bus.dn_go = 1'b1;
        tick();
        bus.execute_enable = 1'b1;
        bus.execute_addr   = 16'hBEEF;
        send_byte(16'h0501, 8'hC2);
        bus.execute_enable = 1'b0;
        bus.dn_go = 1'b0;
        tick();
        ack_mode = 1;
        wait_idle("rt2_idle_timeout");
        tick();
        check("rt2_exec_once", exec_pulses, pulses0 + 1);
        check("rt2_exec_pc", exec_pc_seen, 16'hBEEF);
        check("rt2_byte_count", byte_count, 2);
        check("rt2_q_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
